// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store traffic onto one RAM port.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; default is data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddress,
    output logic              fetchAck,
    output logic [DATA_W-1:0] fetchData,
    input  logic              dataReadReq,
    input  logic              dataWriteReq,
    input  logic [ADDR_W-1:0] dataAddress,
    input  logic [DATA_W-1:0] dataWriteValue,
    output logic              dataAck,
    output logic [DATA_W-1:0] dataReadValue,
    input  logic [DATA_W-1:0] ramValue,
    input  logic              readAck,
    input  logic              writeAck,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [DATA_W-1:0] ramOut,
    output logic              readReq,
    output logic              writeReq,
    output logic              grantId,
    output logic              busError
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic [DATA_W-1:0] ddata_q, ddata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              gid_q, gid_d;
    logic              rreq_q, rreq_d;
    logic              wreq_q, wreq_d;
    logic              fack_q, fack_d;
    logic              dack_q, dack_d;
    logic              berr_q, berr_d;
    logic              data_req, pick_data, ack_ok, wr_sel;

    assign data_req = dataReadReq | dataWriteReq;
    // A simultaneous read+write on the data port is treated as a write.
    assign wr_sel   = pick_data & dataWriteReq;
    assign ack_ok   = wr_q ? writeAck : readAck;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign last_grant = gid_q;
    assign pick_data  = data_req & (~fetchReq | ~last_grant);
`else
    assign pick_data  = data_req;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fdata_d = fdata_q;
        ddata_d = ddata_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        gid_d   = gid_q;
        berr_d  = berr_q;
        rreq_d  = 1'b0;
        wreq_d  = 1'b0;
        fack_d  = 1'b0;
        dack_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetchReq | data_req) begin
                    state_d = ISSUE;
                    gid_d   = pick_data;
                    wr_d    = wr_sel;
                    rreq_d  = ~wr_sel;
                    wreq_d  = wr_sel;
                    if (pick_data) begin
                        addr_d  = dataAddress;
                        wdata_d = dataWriteValue;
                    end else begin
                        addr_d  = fetchAddress;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (ack_ok) begin
                    state_d = RESP;
                    fack_d  = ~gid_q;
                    dack_d  = gid_q;
                    if (gid_q) ddata_d = wr_q ? '0 : ramValue;
                    else       fdata_d = ramValue;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO) begin
                        state_d = RESP;
                        berr_d  = 1'b1;
                        fack_d  = ~gid_q;
                        dack_d  = gid_q;
                        if (gid_q) ddata_d = '0;
                        else       fdata_d = '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            fdata_q <= '0;
            ddata_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            gid_q   <= 1'b0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
            fack_q  <= 1'b0;
            dack_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fdata_q <= fdata_d;
            ddata_q <= ddata_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            gid_q   <= gid_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
            fack_q  <= fack_d;
            dack_q  <= dack_d;
            berr_q  <= berr_d;
        end
    end

    assign ramAddress    = addr_q;
    assign ramOut        = wdata_q;
    assign readReq       = rreq_q;
    assign writeReq      = wreq_q;
    assign fetchAck      = fack_q;
    assign dataAck       = dack_q;
    assign fetchData     = fdata_q;
    assign dataReadValue = ddata_q;
    assign grantId       = gid_q;
    assign busError      = berr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a small behavioural RAM.
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetchReq, dataReadReq, dataWriteReq;
    logic [31:0] fetchAddress, dataAddress, dataWriteValue;
    logic        fetchAck, dataAck;
    logic [31:0] fetchData, dataReadValue;
    logic [31:0] ramValue = '0;
    logic        readAck = 1'b0;
    logic        writeAck = 1'b0;
    logic [31:0] ramAddress, ramOut;
    logic        readReq, writeReq, grantId, busError;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .fetchReq(fetchReq), .fetchAddress(fetchAddress),
        .fetchAck(fetchAck), .fetchData(fetchData),
        .dataReadReq(dataReadReq), .dataWriteReq(dataWriteReq),
        .dataAddress(dataAddress), .dataWriteValue(dataWriteValue),
        .dataAck(dataAck), .dataReadValue(dataReadValue),
        .ramValue(ramValue), .readAck(readAck), .writeAck(writeAck),
        .ramAddress(ramAddress), .ramOut(ramOut),
        .readReq(readReq), .writeReq(writeReq),
        .grantId(grantId), .busError(busError)
    );

    // RAM model: acks dly cycles after sampling a request
    logic [31:0] mem [0:63];
    int          dly = 1;
    bit          ram_on = 1'b1;
    bit          stray = 1'b0;
    int          cd = 0;
    logic        pw = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    int          both_cnt = 0;

    always @(posedge clk) begin
        readAck  <= 1'b0;
        writeAck <= stray;
        if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
                if (pw) begin
                    writeAck     <= 1'b1;
                    mem[pa[7:2]] <= pd;
                end else begin
                    readAck  <= 1'b1;
                    ramValue <= mem[pa[7:2]];
                end
            end
        end
        if (ram_on && (readReq || writeReq)) begin
            cd <= dly;
            pw <= writeReq;
            pa <= ramAddress;
            pd <= ramOut;
        end
    end

    always @(negedge clk)
        if (readReq && writeReq) both_cnt <= both_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit hold, output int lat, output int nrd,
                       output int nwr, output logic fa, output logic da,
                       output logic g, output logic [31:0] d,
                       output logic [31:0] ra, output logic [31:0] ro);
        lat = 0; nrd = 0; nwr = 0;
        fa = 0; da = 0; g = 0; d = '0; ra = '0; ro = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (readReq || writeReq) begin
                ra = ramAddress;
                ro = ramOut;
            end
            nrd += int'(readReq);
            nwr += int'(writeReq);
            if (fetchAck || dataAck) begin
                lat = i;
                fa  = fetchAck;
                da  = dataAck;
                g   = grantId;
                d   = fetchAck ? fetchData : dataReadValue;
                break;
            end
        end
        if (!hold) begin
            fetchReq     = 1'b0;
            dataReadReq  = 1'b0;
            dataWriteReq = 1'b0;
        end
    endtask

    task automatic ack_low(input string tag);
        @(posedge clk); #1;
        chk(tag, 32'({fetchAck, dataAck}), 32'd0);
    endtask

    int          lat, nrd, nwr, acks;
    logic        fa, da, g;
    logic [31:0] d, ra, ro;
    logic [31:0] exp_d [0:2];
    logic        exp_g [0:2];

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1;
        exp_d[0] = 32'h12345678; exp_d[1] = 32'hA1B2C3D4;
        exp_d[2] = 32'h12345678;
`else
        exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b1;
        exp_d[0] = 32'h12345678; exp_d[1] = 32'h12345678;
        exp_d[2] = 32'h12345678;
`endif
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD0000 | i;
        mem[4]  = 32'hA1B2C3D4;
        mem[12] = 32'h5555AAAA;
        reset = 1'b0;
        fetchReq = 0; dataReadReq = 0; dataWriteReq = 0;
        fetchAddress = '0; dataAddress = '0; dataWriteValue = '0;

        #12;
        chk("rst_reqack", 32'({readReq, writeReq, fetchAck, dataAck}), 32'd0);
        chk("rst_addr", ramAddress, 32'd0);
        chk("rst_out", ramOut, 32'd0);
        chk("rst_rdata", fetchData | dataReadValue, 32'd0);
        chk("rst_gid_berr", 32'({grantId, busError}), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        // single fetch
        fetchAddress = 32'h10;
        fetchReq = 1'b1;
        txn(0, lat, nrd, nwr, fa, da, g, d, ra, ro);
        chk("f_lat", 32'(lat), 32'd4);
        chk("f_port", 32'({fa, da}), 32'd2);
        chk("f_data", d, 32'hA1B2C3D4);
        chk("f_gid", 32'(g), 32'd0);
        chk("f_rdpulse", 32'(nrd), 32'd1);
        chk("f_wrpulse", 32'(nwr), 32'd0);
        chk("f_ramaddr", ra, 32'h10);
        ack_low("f_acklow");

        // store with read also high: write must win
        @(negedge clk);
        dataAddress = 32'h20;
        dataWriteValue = 32'h12345678;
        dataWriteReq = 1'b1;
        dataReadReq = 1'b1;
        txn(0, lat, nrd, nwr, fa, da, g, d, ra, ro);
        chk("w_lat", 32'(lat), 32'd4);
        chk("w_port", 32'({fa, da}), 32'd1);
        chk("w_gid", 32'(g), 32'd1);
        chk("w_wrpulse", 32'(nwr), 32'd1);
        chk("w_rdpulse", 32'(nrd), 32'd0);
        chk("w_ramout", ro, 32'h12345678);
        chk("w_ramaddr", ra, 32'h20);
        chk("w_mem", mem[8], 32'h12345678);
        ack_low("w_acklow");

        // load back the stored word
        @(negedge clk);
        dataReadReq = 1'b1;
        txn(0, lat, nrd, nwr, fa, da, g, d, ra, ro);
        chk("rb_lat", 32'(lat), 32'd4);
        chk("rb_port", 32'({fa, da}), 32'd1);
        chk("rb_data", d, 32'h12345678);
        ack_low("rb_acklow");

        // stray writeAck during read WAIT, real readAck delayed
        @(negedge clk);
        dly = 4;
        fetchAddress = 32'h10;
        fetchReq = 1'b1;
        fork
            txn(0, lat, nrd, nwr, fa, da, g, d, ra, ro);
            begin
                repeat (2) @(posedge clk);
                #1 stray = 1'b1;
                @(posedge clk);
                #1 stray = 1'b0;
            end
        join
        dly = 1;
        chk("s_lat", 32'(lat), 32'd7);
        chk("s_port", 32'({fa, da}), 32'd2);
        chk("s_data", d, 32'hA1B2C3D4);
        ack_low("s_acklow");

        // both ports held for three transactions
        @(negedge clk);
        fetchAddress = 32'h10;
        dataAddress = 32'h20;
        fetchReq = 1'b1;
        dataReadReq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            txn(k == 2 ? 1'b0 : 1'b1, lat, nrd, nwr, fa, da, g, d, ra, ro);
            chk($sformatf("arb%0d_lat", k), 32'(lat), k == 0 ? 32'd4 : 32'd5);
            chk($sformatf("arb%0d_gid", k), 32'(g), 32'(exp_g[k]));
            chk($sformatf("arb%0d_port", k), 32'({fa, da}),
                exp_g[k] ? 32'd1 : 32'd2);
            chk($sformatf("arb%0d_data", k), d, exp_d[k]);
        end
        ack_low("arb_acklow");

        // RAM never answers: timeout after 8 WAIT cycles
        chk("t_berr_pre", 32'(busError), 32'd0);
        @(negedge clk);
        ram_on = 1'b0;
        fetchAddress = 32'h30;
        fetchReq = 1'b1;
        txn(0, lat, nrd, nwr, fa, da, g, d, ra, ro);
        chk("t_lat", 32'(lat), 32'd10);
        chk("t_port", 32'({fa, da}), 32'd2);
        chk("t_data", d, 32'd0);
        chk("t_berr", 32'(busError), 32'd1);
        ack_low("t_acklow");
        repeat (3) @(posedge clk);
        #1 chk("t_berr_sticky", 32'(busError), 32'd1);

        // reset during WAIT
        @(negedge clk);
        fetchAddress = 32'h10;
        fetchReq = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("r_addr_pre", ramAddress, 32'h10);
        #1 reset = 1'b0;
        fetchReq = 1'b0;
        #1;
        chk("r_reqack", 32'({readReq, writeReq, fetchAck, dataAck}), 32'd0);
        chk("r_addr", ramAddress, 32'd0);
        chk("r_berr", 32'(busError), 32'd0);
        chk("r_rdata", fetchData | dataReadValue, 32'd0);
        @(negedge clk) reset = 1'b1;
        ram_on = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            acks += int'(fetchAck) + int'(dataAck);
        end
        chk("r_noack", 32'(acks), 32'd0);
        @(negedge clk);
        fetchReq = 1'b1;
        txn(0, lat, nrd, nwr, fa, da, g, d, ra, ro);
        chk("r_f_lat", 32'(lat), 32'd4);
        chk("r_f_data", d, 32'hA1B2C3D4);
        ack_low("r_acklow");

        chk("never_both", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
